// File: rtl/alu_exec.sv
// Execute-stage ALU. Single-cycle logic/arith/compare ops finish with one
// registered cycle of latency. MUL is an iterative shift-add that runs for WIDTH
// cycles behind a start/busy/done handshake.
module alu_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [3:0]       i_alu_ctrl,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpMul = 4'b1000;

  typedef enum logic [0:0] {
    StIdle,
    StMul
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_done;
  logic             r_busy;

  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_slt;
  logic             w_last_iter;

  // Single-cycle datapath; MUL and unassigned codes yield zero here.
  always_comb begin
    w_alu_res = '0;
    w_slt     = ($signed(i_op_a) < $signed(i_op_b));
    case (i_alu_ctrl)
      OpAnd:   w_alu_res = i_op_a & i_op_b;
      OpOr:    w_alu_res = i_op_a | i_op_b;
      OpAdd:   w_alu_res = i_op_a + i_op_b;
      OpSub:   w_alu_res = i_op_a - i_op_b;
      OpSlt:   w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_alu_res = '0;
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    w_acc_next  = r_b[0] ? (r_acc + r_a) : r_acc;
    w_last_iter = (r_cnt == CNT_W'(1));
  end

  // Control FSM with registered outputs; start is only looked at in StIdle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (i_alu_ctrl == OpMul) begin
              r_acc   <= '0;
              r_a     <= i_op_a;
              r_b     <= i_op_b;
              r_cnt   <= CNT_W'(WIDTH);
              r_busy  <= 1'b1;
              r_state <= StMul;
            end else begin
              r_result <= w_alu_res;
              r_zero   <= (w_alu_res == '0);
              r_done   <= 1'b1;
            end
          end
        end
        StMul: begin
          r_acc <= w_acc_next;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last_iter) begin
            r_result <= w_acc_next;
            r_zero   <= (w_acc_next == '0);
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_zero   = r_zero;

endmodule
